m68k_dtack_wait_gen: RTL
========================

Name: m68k_dtack_wait_gen

Overview:
- Bus-cycle terminator sitting directly downstream of the 68000 address decoder.
- Consumes the decoded region selects plus the CPU strobes, then drives DTACK_L back to the CPU.
- Fixed-latency regions (ROM, on-chip RAM, IO) are terminated after a per-region programmable wait-state count; self-timed regions (DRAM, CAN, graphics) are terminated by their own device acknowledge.
- Unmapped or hung cycles are terminated with BERR_L after a timeout, and the faulting address is captured for the debugger.

Parameters:
ROM_WAIT, 0, wait-state clocks for OnChipRomSelect_H cycles (0..TIMEOUT_CYCLES-1)
RAM_WAIT, 0, wait-state clocks for OnChipRamSelect_H cycles
IO_WAIT, 3, wait-state clocks for IOSelect_H cycles
TIMEOUT_CYCLES, 255, clocks from cycle start to BERR; counter is 16 bits, legal range 2..65535

Ports:
Clk  input  1  system clock; the CPU is clocked from the same net and all inputs are synchronous
Reset_H  input  1  asynchronous active-high reset
AS_L  input  1  CPU address strobe
UDS_L  input  1  upper data strobe
LDS_L  input  1  lower data strobe
Address  input  32  CPU address, for fault capture
OnChipRomSelect_H  input  1  decoder select
OnChipRamSelect_H  input  1  decoder select
IOSelect_H  input  1  decoder select
DramSelect_H  input  1  decoder select
CanBusSelect_H  input  1  decoder select
GraphicsCS_L  input  1  decoder select (active low)
DramDtack_L  input  1  DRAM controller acknowledge
CanBusDtack_L  input  1  CAN controller acknowledge
GraphicsDtack_L  input  1  graphics controller acknowledge
DTACK_L  output  1  registered data acknowledge to CPU
BERR_L  output  1  registered bus error to CPU
FaultAddress  output  32  address of the most recent BERR cycle
FaultValid_H  output  1  sticky; set on BERR, cleared only by reset

Behaviour:
- Reset (async, any state): DTACK_L=1, BERR_L=1, FaultAddress=0, FaultValid_H=0, state=IDLE, counter=0.
- All outputs are registered on Clk rising edges. "Edge E0" is the first edge at which IDLE samples AS_L=0 and (UDS_L=0 or LDS_L=0).
- Region priority at E0 when more than one select is active: ROM > RAM > IO > DRAM > CAN > Graphics. No select active means unmapped. The region is latched at E0 and ignored thereafter.
- States: IDLE, WAIT, EXT, ACK, ERR.
- IDLE -> ACK at E0 for fixed regions with wait=0; DTACK_L=0 after E0.
- IDLE -> WAIT at E0 for fixed regions with wait=N>0; counter loads N-1; DTACK_L=0 after edge E0+N.
- IDLE -> EXT at E0 for DRAM, CAN and Graphics; DTACK_L=0 after the first edge (E0 included) at which the latched region's device Dtack_L is sampled 0.
- IDLE -> EXT at E0 for unmapped cycles; these wait only for the timeout.
- Timeout: a 16-bit counter runs from E0 in WAIT and EXT. If no acknowledge occurs by edge E0+TIMEOUT_CYCLES, go to ERR: BERR_L=0, FaultAddress=Address sampled at E0, FaultValid_H=1. DTACK_L stays 1.
- If device Dtack_L goes low on the same edge the timeout expires, DTACK wins: no BERR, no capture.
- ACK and ERR hold their asserted output until AS_L is sampled 1. On that edge the output returns to 1 and the state goes to IDLE. Minimum one idle clock between cycles.
- AS_L sampled 1 while in WAIT or EXT (aborted cycle): go to IDLE at that edge, outputs stay 1, no fault recorded.
- DTACK_L and BERR_L are never 0 simultaneously.
- A new cycle starts only from IDLE, so a held-low AS_L never causes re-triggering.
- FaultAddress is overwritten by each new BERR.

Test Plan:
- ROM read at 0x0000_0100, ROM_WAIT=0: AS_L/LDS_L low at E0 -> DTACK_L low after E0; AS_L high -> DTACK_L high the next edge.
- IO write at 0x0040_0010, IO_WAIT=3 -> DTACK_L low exactly after E0+3, not before; BERR_L stays 1.
- DRAM read at 0x0800_0000 with DramDtack_L low at E0+7 -> DTACK_L low after E0+7; then force DramDtack_L low at the E0+TIMEOUT_CYCLES edge -> DTACK only, no BERR.
- Unmapped address 0x2000_0000, TIMEOUT_CYCLES=16 -> BERR_L low after E0+16, FaultAddress=0x2000_0000, FaultValid_H=1; BERR_L released after AS_L high.
- Both ROM and DRAM selects high -> ROM timing is used and DramDtack_L is ignored. AS_L raised at E0+1 during IO_WAIT=3 -> no DTACK, no BERR, back to IDLE.
- Reset_H pulsed mid-cycle while DTACK_L=0 -> DTACK_L=1 immediately (before the next edge), FaultValid_H=0, and the next cycle behaves normally.

Source files
------------

// File: rtl/m68k_dtack_wait_gen.sv
// 68000 bus-cycle terminator: DTACK after programmable waits or a device acknowledge,
// and BERR with fault-address capture when a cycle times out.
module m68k_dtack_wait_gen #(
    parameter int unsigned ROM_WAIT       = 0,
    parameter int unsigned RAM_WAIT       = 0,
    parameter int unsigned IO_WAIT        = 3,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        Clk,
    input  logic        Reset_H,
    input  logic        AS_L,
    input  logic        UDS_L,
    input  logic        LDS_L,
    input  logic [31:0] Address,
    input  logic        OnChipRomSelect_H,
    input  logic        OnChipRamSelect_H,
    input  logic        IOSelect_H,
    input  logic        DramSelect_H,
    input  logic        CanBusSelect_H,
    input  logic        GraphicsCS_L,
    input  logic        DramDtack_L,
    input  logic        CanBusDtack_L,
    input  logic        GraphicsDtack_L,
    output logic        DTACK_L,
    output logic        BERR_L,
    output logic [31:0] FaultAddress,
    output logic        FaultValid_H
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_EXT,
        S_ACK,
        S_ERR
    } state_t;

    typedef enum logic [2:0] {
        R_ROM,
        R_RAM,
        R_IO,
        R_DRAM,
        R_CAN,
        R_GFX,
        R_NONE
    } region_t;

    localparam logic [15:0] ROM_W = 16'(ROM_WAIT);
    localparam logic [15:0] RAM_W = 16'(RAM_WAIT);
    localparam logic [15:0] IO_W  = 16'(IO_WAIT);
    localparam logic [15:0] TMO   = 16'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    region_t     region_q, region_d;
    logic [15:0] wait_q, wait_d;
    logic [15:0] tmo_q, tmo_d;
    logic [31:0] addr_q, addr_d;
    logic        dtack_q, dtack_d;
    logic        berr_q, berr_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic        fault_valid_q, fault_valid_d;

    logic        cycle_start;
    region_t     region_sel;
    logic [15:0] sel_wait;
    logic        sel_fixed;
    logic        ack_start;
    logic        ack_now;

    assign cycle_start = !AS_L && (!UDS_L || !LDS_L);

    function automatic logic dev_ack(input region_t r, input logic dram_l,
                                     input logic can_l, input logic gfx_l);
        logic a;
        a = 1'b0;
        case (r)
            R_DRAM:  a = !dram_l;
            R_CAN:   a = !can_l;
            R_GFX:   a = !gfx_l;
            default: a = 1'b0;
        endcase
        return a;
    endfunction

    // Priority decode of the selects; only meaningful at the cycle start edge
    always_comb begin
        region_sel = R_NONE;
        if (OnChipRomSelect_H)      region_sel = R_ROM;
        else if (OnChipRamSelect_H) region_sel = R_RAM;
        else if (IOSelect_H)        region_sel = R_IO;
        else if (DramSelect_H)      region_sel = R_DRAM;
        else if (CanBusSelect_H)    region_sel = R_CAN;
        else if (!GraphicsCS_L)     region_sel = R_GFX;
    end

    // Wait count and region class for the region being decoded
    always_comb begin
        sel_wait  = 16'd0;
        sel_fixed = 1'b0;
        case (region_sel)
            R_ROM: begin
                sel_wait  = ROM_W;
                sel_fixed = 1'b1;
            end
            R_RAM: begin
                sel_wait  = RAM_W;
                sel_fixed = 1'b1;
            end
            R_IO: begin
                sel_wait  = IO_W;
                sel_fixed = 1'b1;
            end
            default: begin
                sel_wait  = 16'd0;
                sel_fixed = 1'b0;
            end
        endcase
    end

    assign ack_start = dev_ack(region_sel, DramDtack_L,
                               CanBusDtack_L, GraphicsDtack_L);
    assign ack_now   = dev_ack(region_q, DramDtack_L,
                               CanBusDtack_L, GraphicsDtack_L);

    // State and output registers
    always_ff @(posedge Clk or posedge Reset_H) begin
        if (Reset_H) begin
            state_q       <= S_IDLE;
            region_q      <= R_NONE;
            wait_q        <= 16'd0;
            tmo_q         <= 16'd0;
            addr_q        <= 32'd0;
            dtack_q       <= 1'b1;
            berr_q        <= 1'b1;
            fault_addr_q  <= 32'd0;
            fault_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            region_q      <= region_d;
            wait_q        <= wait_d;
            tmo_q         <= tmo_d;
            addr_q        <= addr_d;
            dtack_q       <= dtack_d;
            berr_q        <= berr_d;
            fault_addr_q  <= fault_addr_d;
            fault_valid_q <= fault_valid_d;
        end
    end

    // Next state: acknowledge beats timeout; AS_L high aborts an open cycle
    always_comb begin
        state_d  = state_q;
        region_d = region_q;
        wait_d   = wait_q;
        tmo_d    = tmo_q;
        addr_d   = addr_q;
        case (state_q)
            S_IDLE: begin
                if (cycle_start) begin
                    region_d = region_sel;
                    addr_d   = Address;
                    tmo_d    = 16'd1;
                    wait_d   = 16'd0;
                    if (sel_fixed) begin
                        if (sel_wait == 16'd0) begin
                            state_d = S_ACK;
                        end else begin
                            state_d = S_WAIT;
                            wait_d  = sel_wait - 16'd1;
                        end
                    end else if (ack_start) begin
                        state_d = S_ACK;
                    end else begin
                        state_d = S_EXT;
                    end
                end
            end
            S_WAIT: begin
                if (AS_L) begin
                    state_d = S_IDLE;
                end else if (wait_q == 16'd0) begin
                    state_d = S_ACK;
                end else if (tmo_q == TMO) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q - 16'd1;
                    tmo_d  = tmo_q + 16'd1;
                end
            end
            S_EXT: begin
                if (AS_L) begin
                    state_d = S_IDLE;
                end else if (ack_now) begin
                    state_d = S_ACK;
                end else if (tmo_q == TMO) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_ACK, S_ERR: begin
                if (AS_L) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs follow the next state; fault captured on entry to ERR
    always_comb begin
        dtack_d       = (state_d != S_ACK);
        berr_d        = (state_d != S_ERR);
        fault_addr_d  = fault_addr_q;
        fault_valid_d = fault_valid_q;
        if (state_d == S_ERR && state_q != S_ERR) begin
            fault_addr_d  = addr_q;
            fault_valid_d = 1'b1;
        end
    end

    assign DTACK_L      = dtack_q;
    assign BERR_L       = berr_q;
    assign FaultAddress = fault_addr_q;
    assign FaultValid_H = fault_valid_q;

endmodule
